// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and the data memory.
// One request at a time: IDLE -> ACCESS -> RESP, faults skip ACCESS.
module lsu_ctrl #(
    parameter int MEM_AW = 11,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_misalign,
    output logic              o_rsp_afault,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic        we_q;
    logic [2:0]  f3_q;

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        misalign;
    logic        afault;
    logic        accept;
    logic [3:0]  bmask_nx;
    logic [31:0] ext;

    assign is_b = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b100);
    assign is_h = (i_req_funct3 == 3'b001) || (i_req_funct3 == 3'b101);
    assign is_w = (i_req_funct3 == 3'b010);

    assign misalign = (is_h && i_req_addr[0])
                    || (is_w && (i_req_addr[1:0] != 2'b00));
    assign afault = (i_req_addr[XLEN-1:MEM_AW] != '0)
                  || !(is_b || is_h || is_w);

    assign accept = (state == IDLE) && i_req_valid;

    always_comb begin
        bmask_nx = 4'b0001;
        if (is_w)      bmask_nx = 4'b1111;
        else if (is_h) bmask_nx = 4'b0011;
    end

    always_comb begin
        ext = i_mem_rdata;
        case (f3_q)
            3'b000:  ext = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
            3'b100:  ext = {24'b0, i_mem_rdata[7:0]};
            3'b001:  ext = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            3'b101:  ext = {16'b0, i_mem_rdata[15:0]};
            default: ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        state_nx    = state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_wren  = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    state_nx = (misalign || afault) ? RESP : ACCESS;
            end
            ACCESS: begin
                // reset in the same cycle must suppress the write
                o_mem_wren = we_q && !i_reset;
                state_nx   = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            f3_q           <= 3'b010;
            o_rsp_rdata    <= '0;
            o_rsp_misalign <= 1'b0;
            o_rsp_afault   <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_mem_bmask    <= 4'b1111;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q <= i_req_we;
                f3_q <= i_req_funct3;
                if (misalign || afault) begin
                    o_rsp_rdata    <= '0;
                    o_rsp_misalign <= misalign;
                    o_rsp_afault   <= !misalign;
                end else begin
                    // memory port only moves for requests that will access it
                    o_mem_addr  <= i_req_addr[MEM_AW-1:0];
                    o_mem_wdata <= i_req_wdata[31:0];
                    o_mem_bmask <= bmask_nx;
                end
            end
            if (state == ACCESS) begin
                o_rsp_rdata    <= we_q ? '0 : XLEN'(ext);
                o_rsp_misalign <= 1'b0;
                o_rsp_afault   <= 1'b0;
            end
        end
    end

endmodule
